wb_quad_decoder: RTL and testbench
==================================

# wb_quad_decoder

Wishbone-slave quadrature decoder for the wheel encoder inputs. It samples the 3-wire encoder bus (A, B, index), filters it, and decodes A/B Gray transitions into a signed-step position counter with direction, index latch, and error/overflow flags. Registers are readable and writable over the same Wishbone bus used by the encoder monitor. Interrupts are raised to the PLB side on enabled events.

## Interface
- C_WB_DWIDTH, 32, data/address width; buses are big-endian `[0:C_WB_DWIDTH-1]`, value bit n = bus bit C_WB_DWIDTH-1-n
- C_WB_BASEADDR, 32'h0, block base; a 16-byte window is decoded
- C_CNT_WIDTH, 16, position counter width (2..C_WB_DWIDTH)
- C_FILT_LEN, 3, consecutive equal samples required to accept an input level (1..15)
- wb_clk_i  in  1  single clock for all logic
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle/strobe/write
- wb_addr_i  in  C_WB_DWIDTH  byte address
- wb_data_i  in  C_WB_DWIDTH  write data
- wb_data_o  out  C_WB_DWIDTH  read data, 0 when not acking
- wb_ack_o  out  1  single-cycle acknowledge
- irq_o  out  1  level interrupt, registered
- enc_data  in  3  `[0]`=A, `[1]`=B, `[2]`=index; asynchronous to wb_clk_i

## Operation
- Registers, word offset from base (value bit numbering):
  - 0x0 POS (R/W): counter zero-extended; write loads value[C_CNT_WIDTH-1:0]
  - 0x4 STATUS: b0 DIR (RO, 1=forward), b1 IDX, b2 ERR, b3 OVF (sticky, write-1-to-clear)
  - 0x8 CTRL (R/W): b0 EN, b1 IDX_IE, b2 ERR_IE, b3 OVF_IE, b4 IDXCLR
  - 0xC LATCH (RO): counter value captured on index rising edge
- Unmapped offsets and out-of-window addresses: read 0, writes ignored, still acked.
- Input path per wire: 2-flop synchronizer, then filter; the filtered output changes only after C_FILT_LEN identical consecutive synchronized samples.
- Decode on filtered {A,B}, prev vs curr: 00→01→11→10→00 = +1, reverse = −1, no change = none, both bits changed = ERR set, no count, DIR unchanged. prev always updates, including when EN=0.
- With EN=0: no count, no OVF, and no DIR update; ERR and IDX still set.
- Counter wraps modulo 2^C_CNT_WIDTH; OVF is set on max→0 or 0→max.
- Index rising edge: LATCH ← counter value before this cycle's step; IDX set; if IDXCLR=1 and EN=1, counter ← 0.
- Same-cycle priority on counter: Wishbone POS write > index clear > step.
- Same-cycle priority on flags: a hardware set beats a W1C of the same bit.
- irq_o ← |(STATUS[3:1] & CTRL[3:1]), registered.

## Timing
- Reset values: wb_ack_o=0, wb_data_o=0, irq_o=0, counter=0, LATCH=0, STATUS=0, CTRL=0; filters and prev = 00/0, so there is no step out of reset.
- Ack: wb_ack_o ← cyc & stb & ~wb_ack_o. This gives one wait state per access; a held strobe gives one ack every 2 cycles.
- Read data is registered alongside ack and reflects register state at the cycle stb is sampled.
- Writes take effect on the sampling edge, so a read on the next access sees the new value.
- Pin-to-counter latency: 2 (sync) + C_FILT_LEN (filter) + 1 (counter) cycles. irq_o follows the flag by 1 cycle.
- Pulses shorter than C_FILT_LEN cycles are rejected entirely.
- Reset assertion mid-transfer: ack drops immediately, and the interrupted access has no effect.

## Structure
- Shared `define header wb_quad_defs.vh holds:
  - register offsets
  - STATUS/CTRL bit positions
  - Gray step encodings
- Sub-module quad_input_filter (synchronizer + stability counter, 1 bit, parameter C_FILT_LEN), instantiated 3×.
- Top contains the decode, counter, flags, and Wishbone logic.

## Test plan
- Reset, then read all 4 offsets → all 0, irq_o=0, one ack per access with ack low in between.
- CTRL=0x1; drive 8 forward Gray steps, each held 10 cycles → POS=8, DIR=1. Then 3 reverse steps → POS=5, DIR=0.
- POS=0xFFFF, C_CNT_WIDTH=16, CTRL=0x9, one forward step → POS=0, OVF=1, irq_o=1. Write STATUS=0x8 → OVF=0, irq_o=0.
- AB 00→11 directly → ERR=1, POS unchanged. A 2-cycle glitch on A with C_FILT_LEN=3 → no count, no ERR.
- CTRL=0x13, POS=0x0042, index pulse → LATCH=0x0042, POS=0, IDX=1, irq_o=1. Index coincident with a POS write of 7 → POS=7.
- Assert wb_rst_n_i mid-count and mid-read → all outputs 0 immediately. After release, the first steps decode from 00 with no spurious count.

Source files
------------

// File: rtl/wb_quad_decoder_pkg.sv
// Shared definitions for the Wishbone quadrature decoder:
// register offsets, STATUS/CTRL bit positions and Gray decode helpers.
package wb_quad_decoder_pkg;

   localparam logic [1:0] OFF_POS    = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_LATCH  = 2'd3;

   localparam int ST_DIR = 0;
   localparam int ST_IDX = 1;
   localparam int ST_ERR = 2;
   localparam int ST_OVF = 3;

   localparam int CT_EN     = 0;
   localparam int CT_IDX_IE = 1;
   localparam int CT_ERR_IE = 2;
   localparam int CT_OVF_IE = 3;
   localparam int CT_IDXCLR = 4;

   // Forward sequence of {A,B}
   localparam logic [1:0] GRAY_0 = 2'b00;
   localparam logic [1:0] GRAY_1 = 2'b01;
   localparam logic [1:0] GRAY_2 = 2'b11;
   localparam logic [1:0] GRAY_3 = 2'b10;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_FWD,
      STEP_REV,
      STEP_ERR
   } step_e;

   function automatic logic [1:0] gray_next(input logic [1:0] ab);
      logic [1:0] nxt;
      unique case (ab)
         GRAY_0:  nxt = GRAY_1;
         GRAY_1:  nxt = GRAY_2;
         GRAY_2:  nxt = GRAY_3;
         default: nxt = GRAY_0;
      endcase
      return nxt;
   endfunction

   function automatic step_e gray_step(input logic [1:0] prev,
                                       input logic [1:0] curr);
      step_e s;
      if (curr == prev)
         s = STEP_NONE;
      else if (curr == gray_next(prev))
         s = STEP_FWD;
      else if (prev == gray_next(curr))
         s = STEP_REV;
      else
         s = STEP_ERR;
      return s;
   endfunction

endpackage

// File: rtl/wb_quad_decoder_input_filter.sv
// One encoder wire: 2-flop synchronizer followed by a stability filter
// that only follows the input after C_FILT_LEN identical samples.
module wb_quad_decoder_input_filter #(
   parameter int unsigned C_FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam logic [3:0] LAST = 4'(C_FILT_LEN - 1);

   logic       s1;
   logic       s2;
   logic [3:0] cnt;

   // Synchronize the asynchronous pin into the clock domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

   // Count consecutive differing samples; accept the level on the last one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (s2 == dout) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         dout <= s2;
      end else begin
         cnt <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/wb_quad_decoder.sv
// Wishbone-slave quadrature decoder: filtered A/B/index inputs, position
// counter, index latch, sticky flags and a registered interrupt.
module wb_quad_decoder
   import wb_quad_decoder_pkg::*;
#(
   parameter int unsigned                C_WB_DWIDTH   = 32,
   parameter logic [C_WB_DWIDTH-1:0]     C_WB_BASEADDR = '0,
   parameter int unsigned                C_CNT_WIDTH   = 16,
   parameter int unsigned                C_FILT_LEN    = 3
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_n_i,
   input  logic                   wb_cyc_i,
   input  logic                   wb_stb_i,
   input  logic                   wb_we_i,
   input  logic [0:C_WB_DWIDTH-1] wb_addr_i,
   input  logic [0:C_WB_DWIDTH-1] wb_data_i,
   output logic [0:C_WB_DWIDTH-1] wb_data_o,
   output logic                   wb_ack_o,
   output logic                   irq_o,
   input  logic [2:0]             enc_data
);

   localparam int DW = C_WB_DWIDTH;
   localparam int CW = C_CNT_WIDTH;

   // Value-numbered views of the big-endian buses
   logic [DW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rd;
   logic          unused_ok;

   assign addr      = wb_addr_i;
   assign wdata     = wb_data_i;
   assign unused_ok = ^{addr[1:0], wdata};

   logic [2:0] filt;

   wb_quad_decoder_input_filter #(.C_FILT_LEN(C_FILT_LEN)) u_filt_a (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n_i),
      .din   (enc_data[0]),
      .dout  (filt[0])
   );

   wb_quad_decoder_input_filter #(.C_FILT_LEN(C_FILT_LEN)) u_filt_b (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n_i),
      .din   (enc_data[1]),
      .dout  (filt[1])
   );

   wb_quad_decoder_input_filter #(.C_FILT_LEN(C_FILT_LEN)) u_filt_idx (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n_i),
      .din   (enc_data[2]),
      .dout  (filt[2])
   );

   logic [1:0]    prev_ab;
   logic          prev_idx;
   logic [1:0]    curr_ab;
   step_e         step;
   logic          fwd;
   logic          rev;
   logic          en;
   logic          step_ok;
   logic          idx_rise;
   logic          idx_clr;
   logic          ovf_set;

   logic [CW-1:0] cnt;
   logic [CW-1:0] latch;
   logic [4:0]    ctrl;
   logic          dir;
   logic          idx_f;
   logic          err_f;
   logic          ovf_f;

   logic          hit;
   logic          acc;
   logic          wr;
   logic [1:0]    off;
   logic          wr_pos;
   logic          wr_status;
   logic          wr_ctrl;

   assign curr_ab  = {filt[0], filt[1]};
   assign step     = gray_step(prev_ab, curr_ab);
   assign fwd      = (step == STEP_FWD);
   assign rev      = (step == STEP_REV);
   assign en       = ctrl[CT_EN];
   assign step_ok  = en & (fwd | rev);
   assign idx_rise = filt[2] & ~prev_idx;
   assign idx_clr  = idx_rise & en & ctrl[CT_IDXCLR];

   assign hit       = (addr[DW-1:4] == C_WB_BASEADDR[DW-1:4]);
   assign acc       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr        = acc & wb_we_i & hit;
   assign off       = addr[3:2];
   assign wr_pos    = wr & (off == OFF_POS);
   assign wr_status = wr & (off == OFF_STATUS);
   assign wr_ctrl   = wr & (off == OFF_CTRL);

   // Wrap only counts when the step actually lands on the counter
   assign ovf_set = step_ok & ~wr_pos & ~idx_clr &
                    ((fwd & (cnt == '1)) | (rev & (cnt == '0)));

   // Previous filtered levels, tracked even while disabled
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         prev_ab  <= 2'b00;
         prev_idx <= 1'b0;
      end else begin
         prev_ab  <= curr_ab;
         prev_idx <= filt[2];
      end
   end

   // Position counter: bus write beats index clear beats step
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
         cnt <= '0;
      else if (wr_pos)
         cnt <= wdata[CW-1:0];
      else if (idx_clr)
         cnt <= '0;
      else if (step_ok)
         cnt <= fwd ? cnt + CW'(1) : cnt - CW'(1);
   end

   // Capture the pre-step count on each index rising edge
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
         latch <= '0;
      else if (idx_rise)
         latch <= cnt;
   end

   // Direction and sticky flags; a hardware set wins over W1C
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         dir   <= 1'b0;
         idx_f <= 1'b0;
         err_f <= 1'b0;
         ovf_f <= 1'b0;
      end else begin
         if (step_ok)
            dir <= fwd;
         idx_f <= (idx_f & ~(wr_status & wdata[ST_IDX])) | idx_rise;
         err_f <= (err_f & ~(wr_status & wdata[ST_ERR])) |
                  (step == STEP_ERR);
         ovf_f <= (ovf_f & ~(wr_status & wdata[ST_OVF])) | ovf_set;
      end
   end

   // Control register
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
         ctrl <= '0;
      else if (wr_ctrl)
         ctrl <= wdata[4:0];
   end

   // Read mux on the current register state
   always_comb begin
      rd = '0;
      if (hit) begin
         unique case (off)
            OFF_POS:    rd = DW'(cnt);
            OFF_STATUS: begin
               rd[ST_DIR] = dir;
               rd[ST_IDX] = idx_f;
               rd[ST_ERR] = err_f;
               rd[ST_OVF] = ovf_f;
            end
            OFF_CTRL:   rd = DW'(ctrl);
            OFF_LATCH:  rd = DW'(latch);
         endcase
      end
   end

   // Single-cycle ack with registered read data
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wb_ack_o  <= 1'b0;
         wb_data_o <= '0;
      end else begin
         wb_ack_o  <= acc;
         wb_data_o <= (acc && !wb_we_i) ? rd : '0;
      end
   end

   // Level interrupt from enabled sticky flags
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
         irq_o <= 1'b0;
      else
         irq_o <= (idx_f & ctrl[CT_IDX_IE]) |
                  (err_f & ctrl[CT_ERR_IE]) |
                  (ovf_f & ctrl[CT_OVF_IE]);
   end

endmodule

// File: tb/tb_wb_quad_decoder.sv
// Directed bench for wb_quad_decoder: read expectations go through a
// scoreboard queue and are checked when the ack returns.
module tb_wb_quad_decoder;

   localparam logic [31:0] A_POS = 32'h0;
   localparam logic [31:0] A_ST  = 32'h4;
   localparam logic [31:0] A_CT  = 32'h8;
   localparam logic [31:0] A_LA  = 32'hC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [0:31] addr;
   logic [0:31] wdata;
   logic [0:31] rdata;
   logic        ack;
   logic        irq;
   logic [2:0]  enc;

   logic [1:0]  ab;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   wb_quad_decoder dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_we_i    (we),
      .wb_addr_i  (addr),
      .wb_data_i  (wdata),
      .wb_data_o  (rdata),
      .wb_ack_o   (ack),
      .irq_o      (irq),
      .enc_data   (enc)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] gnext(input logic [1:0] v);
      logic [1:0] r;
      case (v)
         2'b00:   r = 2'b01;
         2'b01:   r = 2'b11;
         2'b11:   r = 2'b10;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] gprev(input logic [1:0] v);
      logic [1:0] r;
      case (v)
         2'b00:   r = 2'b10;
         2'b10:   r = 2'b11;
         2'b11:   r = 2'b01;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   task automatic wb_read(input logic [31:0] a, input logic [31:0] exp,
                          input string tag);
      logic [31:0] got;
      logic [31:0] e;
      string       t;
      bit          done;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
      done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         @(posedge clk); #1;
         if (ack) done = 1'b1;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (done) begin
         got = rdata;
         check(t, got, e);
      end else begin
         check({t, "_ack_timeout"}, {31'b0, ack}, 32'd1);
      end
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      check({t, "_ack_gap"}, {31'b0, ack}, 32'd0);
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                           input string tag);
      bit done;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
      done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         @(posedge clk); #1;
         if (ack) done = 1'b1;
      end
      if (!done)
         check({tag, "_ack_timeout"}, {31'b0, ack}, 32'd1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic set_ab(input logic [1:0] v, input int hold);
      @(negedge clk);
      enc[0] = v[1];
      enc[1] = v[0];
      ab = v;
      repeat (hold) @(negedge clk);
   endtask

   task automatic check_irq(input string tag, input logic exp);
      repeat (2) @(posedge clk);
      #1;
      check(tag, {31'b0, irq}, {31'b0, exp});
   endtask

   initial begin
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      addr = '0; wdata = '0; enc = 3'b000; ab = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_ack", {31'b0, ack}, 32'd0);
      check("rst_data", rdata, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      wb_read(A_POS, 32'h0, "rst_pos");
      wb_read(A_ST,  32'h0, "rst_status");
      wb_read(A_CT,  32'h0, "rst_ctrl");
      wb_read(A_LA,  32'h0, "rst_latch");
      wb_write(32'h18, 32'h1F, "oow_wr");
      wb_read(A_CT,  32'h0, "oow_ctrl");
      wb_read(32'h18, 32'h0, "oow_rd");

      wb_write(A_CT, 32'h1, "ctrl_en");
      for (int i = 0; i < 8; i++) set_ab(gnext(ab), 10);
      wb_read(A_POS, 32'd8, "fwd_pos");
      wb_read(A_ST,  32'h1, "fwd_dir");
      for (int i = 0; i < 3; i++) set_ab(gprev(ab), 10);
      wb_read(A_POS, 32'd5, "rev_pos");
      wb_read(A_ST,  32'h0, "rev_dir");

      wb_write(A_POS, 32'hFFFF, "pos_max");
      wb_write(A_CT, 32'h9, "ctrl_ovf");
      set_ab(gnext(ab), 10);
      wb_read(A_POS, 32'h0, "wrap_pos");
      wb_read(A_ST,  32'h9, "wrap_status");
      check_irq("ovf_irq", 1'b1);
      wb_write(A_ST, 32'h8, "ovf_clr");
      wb_read(A_ST,  32'h1, "ovf_cleared");
      check_irq("ovf_irq_clr", 1'b0);

      set_ab(2'b00, 10);
      wb_read(A_POS, 32'h0, "err_pos");
      wb_read(A_ST,  32'h5, "err_status");
      check_irq("err_irq_masked", 1'b0);
      wb_write(A_ST, 32'h4, "err_clr");
      @(negedge clk);
      enc[0] = 1'b1;
      repeat (2) @(negedge clk);
      enc[0] = 1'b0;
      repeat (10) @(negedge clk);
      wb_read(A_POS, 32'h0, "glitch_pos");
      wb_read(A_ST,  32'h1, "glitch_status");

      wb_write(A_CT, 32'h13, "ctrl_idx");
      wb_write(A_POS, 32'h42, "pos_42");
      @(negedge clk);
      enc[2] = 1'b1;
      repeat (10) @(negedge clk);
      enc[2] = 1'b0;
      repeat (10) @(negedge clk);
      wb_read(A_LA,  32'h42, "idx_latch");
      wb_read(A_POS, 32'h0, "idx_clr_pos");
      wb_read(A_ST,  32'h3, "idx_status");
      check_irq("idx_irq", 1'b1);
      wb_write(A_ST, 32'h2, "idx_w1c");
      check_irq("idx_irq_clr", 1'b0);

      @(negedge clk);
      enc[2] = 1'b1;
      repeat (4) @(negedge clk);
      wb_write(A_POS, 32'd7, "pos_vs_idx");
      repeat (10) @(negedge clk);
      enc[2] = 1'b0;
      repeat (10) @(negedge clk);
      wb_read(A_POS, 32'd7, "prio_pos");
      wb_read(A_LA,  32'h0, "prio_latch");
      check_irq("pre_rst_irq", 1'b1);

      set_ab(2'b01, 3);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = A_POS;
      @(posedge clk); #1;
      check("midrd_ack", {31'b0, ack}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_ack", {31'b0, ack}, 32'd0);
      check("midrst_data", rdata, 32'd0);
      check("midrst_irq", {31'b0, irq}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      enc = 3'b000; ab = 2'b00;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      wb_read(A_POS, 32'h0, "post_pos");
      wb_read(A_ST,  32'h0, "post_status");
      wb_read(A_CT,  32'h0, "post_ctrl");
      wb_read(A_LA,  32'h0, "post_latch");
      wb_write(A_CT, 32'h1, "post_en");
      set_ab(gnext(ab), 10);
      set_ab(gnext(ab), 10);
      wb_read(A_POS, 32'd2, "post_steps");
      wb_read(A_ST,  32'h1, "post_dir");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
